// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit (one bit per cycle).
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   start   : one-cycle request, sampled only while idle
//   op      : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b    : operands (multiplicand/dividend, multiplier/divisor)
//   busy    : high from the accepting edge until the result is valid
//   done    : one-cycle pulse, hi/lo valid
//   divzero : set by the last accepted op if it was a divide by zero
//   hi, lo  : product upper/lower half, or remainder/quotient
module muldiv_unit #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         divzero,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo
);

  localparam int unsigned CW = $clog2(n + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t        state_q, state_d;
  logic          div_q, div_d;
  logic          sign_a_q, sign_a_d;
  logic          sign_b_q, sign_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // acc: multiply accumulator (MSB catches the add carry before the shift)
  // or divide partial remainder.
  logic [n:0]    acc_q, acc_d;
  // mq: multiplier shifting out / dividend shifting out and quotient in.
  logic [n-1:0]  mq_q, mq_d;
  logic [n-1:0]  mcand_q, mcand_d;
  logic [n-1:0]  hi_q, hi_d;
  logic [n-1:0]  lo_q, lo_d;
  logic          done_q, done_d;
  logic          divzero_q, divzero_d;

  logic          in_div, in_signed, a_neg, b_neg, b_zero;
  logic [n-1:0]  a_mag, b_mag;
  logic [n:0]    mul_sum;
  logic [n:0]    div_shift;
  logic [n:0]    div_diff;
  logic          div_borrow;
  logic [2*n-1:0] prod, prod_fix;
  logic [n-1:0]  quot, rem;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    divzero_d  = divzero_q;
    done_d     = (state_q == S_FIX);

    in_div     = op[1];
    in_signed  = ~op[0];
    a_neg      = in_signed & a[n-1];
    b_neg      = in_signed & b[n-1];
    b_zero     = (b == '0);
    a_mag      = a_neg ? -a : a;
    b_mag      = b_neg ? -b : b;

    mul_sum    = acc_q + {1'b0, (mq_q[0] ? mcand_q : '0)};
    div_shift  = {acc_q[n-1:0], mq_q[n-1]};
    {div_borrow, div_diff} = {1'b0, div_shift} - {2'b00, mcand_q};

    prod       = {acc_q[n-1:0], mq_q};
    prod_fix   = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quot       = mq_q;
    rem        = acc_q[n-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          div_d     = in_div;
          sign_a_d  = a_neg;
          sign_b_d  = b_neg;
          cnt_d     = CW'(n);
          acc_d     = '0;
          divzero_d = in_div & b_zero;
          if (in_div && b_zero) begin
            // Raw dividend is parked in mq so FIX can return it as hi.
            mq_d    = a;
            mcand_d = '0;
            state_d = S_FIX;
          end else begin
            mq_d    = a_mag;
            mcand_d = b_mag;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (div_q) begin
          // Restoring step: keep the shifted remainder when subtract borrows.
          acc_d = div_borrow ? div_shift : div_diff;
          mq_d  = {mq_q[n-2:0], ~div_borrow};
        end else begin
          acc_d = {1'b0, mul_sum[n:1]};
          mq_d  = {mul_sum[0], mq_q[n-1:1]};
        end
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q && divzero_q) begin
          lo_d = '1;
          hi_d = mq_q;
        end else if (div_q) begin
          lo_d = (sign_a_q ^ sign_b_q) ? -quot : quot;
          hi_d = sign_a_q ? -rem : rem;
        end else begin
          lo_d = prod_fix[n-1:0];
          hi_d = prod_fix[2*n-1:n];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      div_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign divzero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed scenarios plus randomized operations
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a, b;
  logic         busy, done, divzero;
  logic [N-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {divzero, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sp, sq, sr;
    logic [63:0] up;
    logic [31:0] mh, ml;
    logic        dz;
    dz = 1'b0;
    case (o)
      2'b00: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        up = sp;
        mh = up[63:32]; ml = up[31:0];
      end
      2'b01: begin
        up = {32'b0, x} * {32'b0, y};
        mh = up[63:32]; ml = up[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          dz = 1'b1; ml = 32'hFFFF_FFFF; mh = x;
        end else if (o == 2'b10) begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          ml = sq[31:0]; mh = sr[31:0];
        end else begin
          ml = x / y; mh = x % y;
        end
      end
    endcase
    return {dz, mh, ml};
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom_range(3)); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input int elapsed, input int bc0);
    int          cyc;
    int          bc;
    int          exp_lat;
    logic [64:0] e;
    cyc = elapsed;
    bc  = bc0;
    e   = model(o, x, y);
    exp_lat = (o[1] && y == 32'd0) ? 1 : N + 1;
    while (!done && cyc < 200) begin
      if (busy) bc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done"},    64'(done),    64'd1);
    chk({tag, "_latency"}, 64'(cyc),     64'(exp_lat));
    chk({tag, "_busycnt"}, 64'(bc),      64'(exp_lat));
    chk({tag, "_busylow"}, 64'(busy),    64'd0);
    chk({tag, "_hi"},      64'(hi),      64'(e[63:32]));
    chk({tag, "_lo"},      64'(lo),      64'(e[31:0]));
    chk({tag, "_divzero"}, 64'(divzero), 64'(e[64]));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          bc;
    int          ndone;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_divzero", 64'(divzero), 64'd0);
    chk("rst_hi",      64'(hi),      64'd0);
    chk("rst_lo",      64'(lo),      64'd0);
    @(negedge clk); reset = 1'b1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    issue(2'b00, 32'hFFFF_FFF9, 32'd6);
    wait_done("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'd6, 0, 0);
    issue(2'b10, 32'hFFFF_FFEF, 32'd5);
    wait_done("div_neg", 2'b10, 32'hFFFF_FFEF, 32'd5, 0, 0);
    issue(2'b11, 32'd100, 32'd7);
    wait_done("divu", 2'b11, 32'd100, 32'd7, 0, 0);
    issue(2'b11, 32'h0000_1234, 32'd0);
    wait_done("divu_zero", 2'b11, 32'h0000_1234, 32'd0, 0, 0);
    issue(2'b01, 32'd3, 32'd4);
    wait_done("multu_clr", 2'b01, 32'd3, 32'd4, 0, 0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    issue(2'b10, 32'd50, 32'd0);
    wait_done("div_zero", 2'b10, 32'd50, 32'd0, 0, 0);

    // Start pulse while busy must be ignored.
    issue(2'b01, 32'd5, 32'd5);
    bc = 0;
    repeat (9) begin
      if (busy) bc++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    op = 2'b01; a = 32'd7; b = 32'd9; start = 1'b1;
    if (busy) bc++;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore", 2'b01, 32'd5, 32'd5, 10, bc);
    @(posedge clk); #1;
    chk("done_pulse_len", 64'(done), 64'd0);
    chk("ignored_not_run", 64'(busy), 64'd0);

    // Start in the done cycle is accepted at once.
    issue(2'b11, 32'd1000, 32'd33);
    wait_done("b2b_first", 2'b11, 32'd1000, 32'd33, 0, 0);
    issue(2'b00, 32'hFFFF_FF00, 32'hFFFF_FFFE);
    chk("b2b_accept", 64'(busy), 64'd1);
    wait_done("b2b_second", 2'b00, 32'hFFFF_FF00, 32'hFFFF_FFFE, 0, 0);

    // Asynchronous reset mid-operation.
    issue(2'b10, 32'hFFFF_FF9C, 32'd7);
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi",   64'(hi),   64'd0);
    chk("arst_lo",   64'(lo),   64'd0);
    @(negedge clk); reset = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("arst_no_done", 64'(ndone), 64'd0);
    issue(2'b10, 32'hFFFF_FF9C, 32'd7);
    wait_done("after_rst", 2'b10, 32'hFFFF_FF9C, 32'd7, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(3));
      rx = pick();
      ry = pick();
      issue(ro, rx, ry);
      wait_done($sformatf("rand%0d", i), ro, rx, ry, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
